// File: rtl/prefetch_pkg.sv
// Shared types for the touch-only prefetch issue path: cache port structs,
// FSM states, the prediction record and the depth clamp helper.
package prefetch_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 44;
  localparam int unsigned PF_ADDR_W          = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;
  localparam int unsigned PF_DEPTH_W         = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    TAG     = 3'd2,
    WAIT    = 3'd3,
    ADVANCE = 3'd4,
    DONE    = 3'd5
  } pf_state_e;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] index;
    logic [DCACHE_TAG_WIDTH-1:0]   tag;
    logic [DCACHE_INDEX_WIDTH-1:0] step;
    logic [PF_DEPTH_W-1:0]         depth;
  } pf_pred_t;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic [63:0] cached_region_base;
    logic [63:0] cached_region_len;
  } ariane_cfg_t;

  localparam ariane_cfg_t ArianeDefaultConfig = '{
    cached_region_base: 64'h0000_0000_8000_0000,
    cached_region_len:  64'h0000_0000_4000_0000
  };

  function automatic logic [PF_DEPTH_W-1:0] clamp_depth(
    input logic [PF_DEPTH_W-1:0] depth,
    input logic [PF_DEPTH_W-1:0] max_depth
  );
    return (depth > max_depth) ? max_depth : depth;
  endfunction

endpackage

// File: rtl/prefetch_issue_unit_addr_gen.sv
// Stride address step: next = cur + sext(step), flagging a tag (4 KiB page) change.
module pf_addr_gen
  import prefetch_pkg::*;
(
  input  logic [PF_ADDR_W-1:0]          cur_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] step_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   ref_tag_i,
  output logic [PF_ADDR_W-1:0]          next_o,
  output logic                          page_cross_o
);

  logic [PF_ADDR_W-1:0] step_sext_s;

  assign step_sext_s  = {{(PF_ADDR_W - DCACHE_INDEX_WIDTH){step_i[DCACHE_INDEX_WIDTH-1]}}, step_i};
  assign next_o       = cur_i + step_sext_s;
  assign page_cross_o = (next_o[PF_ADDR_W-1 -: DCACHE_TAG_WIDTH] != ref_tag_i);

endmodule

// File: rtl/prefetch_issue_unit.sv
// Issues up to depth touch-only dcache loads along a predicted stride, one at a
// time, yielding to the CPU on abort and never leaving the starting page.
module prefetch_issue_unit
  import prefetch_pkg::*;
#(
  parameter int unsigned PfMaxDepth = 8,
  parameter ariane_cfg_t ArianeCfg  = ArianeDefaultConfig
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] base_index_i,
  input  logic [DCACHE_TAG_WIDTH-1:0]   base_tag_i,
  input  logic [DCACHE_INDEX_WIDTH-1:0] step_i,
  input  logic [PF_DEPTH_W-1:0]         depth_i,
  input  logic                          abort_i,
  output dcache_req_i_t                 pf_port_o,
  input  dcache_req_o_t                 pf_port_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          aborted_o,
  output logic [PF_DEPTH_W-1:0]         issued_o
);

  localparam logic [PF_DEPTH_W-1:0] MaxDepth = PF_DEPTH_W'(PfMaxDepth);
  localparam ariane_cfg_t unused_cfg = ArianeCfg;

  pf_state_e                     state_q, state_d;
  logic [PF_ADDR_W-1:0]          cur_q, cur_d;
  logic [DCACHE_INDEX_WIDTH-1:0] step_q, step_d;
  logic [DCACHE_TAG_WIDTH-1:0]   base_tag_q, base_tag_d;
  logic [PF_DEPTH_W-1:0]         remaining_q, remaining_d;
  logic [PF_DEPTH_W-1:0]         issued_q, issued_d;
  logic                          abort_pend_q, abort_pend_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          aborted_q, aborted_d;

  pf_pred_t                      pred_s;
  logic [PF_ADDR_W-1:0]          ag_cur_s, ag_next_s;
  logic [DCACHE_INDEX_WIDTH-1:0] ag_step_s;
  logic [DCACHE_TAG_WIDTH-1:0]   ag_tag_s;
  logic                          ag_cross_s;
  logic                          unused_rdata_s;

  assign pred_s = '{index: base_index_i, tag: base_tag_i, step: step_i, depth: depth_i};

  // In IDLE the generator computes the first address from the incoming prediction.
  assign ag_cur_s  = (state_q == IDLE) ? {pred_s.tag, pred_s.index} : cur_q;
  assign ag_step_s = (state_q == IDLE) ? pred_s.step : step_q;
  assign ag_tag_s  = (state_q == IDLE) ? pred_s.tag  : base_tag_q;

  pf_addr_gen u_addr_gen (
    .cur_i        (ag_cur_s),
    .step_i       (ag_step_s),
    .ref_tag_i    (ag_tag_s),
    .next_o       (ag_next_s),
    .page_cross_o (ag_cross_s)
  );

  assign unused_rdata_s = ^pf_port_i.data_rdata;

  // Next-state and bookkeeping for the issue sequence.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    step_d       = step_q;
    base_tag_d   = base_tag_q;
    remaining_d  = remaining_q;
    issued_d     = issued_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          cur_d        = ag_next_s;
          step_d       = pred_s.step;
          base_tag_d   = pred_s.tag;
          remaining_d  = clamp_depth(pred_s.depth, MaxDepth);
          issued_d     = {PF_DEPTH_W{1'b0}};
          abort_pend_d = 1'b0;
          if ((pred_s.step == {DCACHE_INDEX_WIDTH{1'b0}}) ||
              (pred_s.depth == {PF_DEPTH_W{1'b0}}) || ag_cross_s) begin
            state_d   = DONE;
            aborted_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A grant in the abort cycle has already committed the index phase.
        if (pf_port_i.data_gnt) begin
          state_d = TAG;
        end else if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      TAG: begin
        if (abort_i) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (pf_port_i.data_rvalid) begin
          state_d = ADVANCE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        abort_pend_d = abort_pend_q | abort_i;
        if (pf_port_i.data_rvalid) begin
          state_d = ADVANCE;
        end else begin
          state_d = WAIT;
        end
      end
      ADVANCE: begin
        issued_d    = issued_q + 4'd1;
        remaining_d = remaining_q - 4'd1;
        if (remaining_q == 4'd1) begin
          state_d = DONE;
        end else if (abort_pend_q || abort_i || ag_cross_s) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          cur_d   = ag_next_s;
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Request port: index phase in REQ, tag phase (or kill) in TAG.
  always_comb begin
    pf_port_o = '0;
    if (state_q == REQ) begin
      pf_port_o.data_req      = ~(abort_i & ~pf_port_i.data_gnt);
      pf_port_o.address_index = cur_q[DCACHE_INDEX_WIDTH-1:0];
    end else if (state_q == TAG) begin
      pf_port_o.address_index = cur_q[DCACHE_INDEX_WIDTH-1:0];
      pf_port_o.address_tag   = cur_q[PF_ADDR_W-1 -: DCACHE_TAG_WIDTH];
      pf_port_o.tag_valid     = ~abort_i;
      pf_port_o.kill_req      = abort_i;
    end else begin
      pf_port_o.data_req = 1'b0;
    end
    if (busy_q) begin
      pf_port_o.data_be   = 8'hFF;
      pf_port_o.data_size = 2'b11;
    end else begin
      pf_port_o.data_be   = 8'h00;
      pf_port_o.data_size = 2'b00;
    end
  end

  // State and registered status flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cur_q        <= {PF_ADDR_W{1'b0}};
      step_q       <= {DCACHE_INDEX_WIDTH{1'b0}};
      base_tag_q   <= {DCACHE_TAG_WIDTH{1'b0}};
      remaining_q  <= {PF_DEPTH_W{1'b0}};
      issued_q     <= {PF_DEPTH_W{1'b0}};
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      step_q       <= step_d;
      base_tag_q   <= base_tag_d;
      remaining_q  <= remaining_d;
      issued_q     <= issued_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign aborted_o = aborted_q;
  assign issued_o  = issued_q;

endmodule

// File: tb/tb_prefetch_issue_unit.sv
// Directed bench for prefetch_issue_unit with a zero-wait cache responder.
module tb_prefetch_issue_unit;
  import prefetch_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [11:0]   base_index_i = 12'h000;
  logic [43:0]   base_tag_i = 44'h5;
  logic [11:0]   step_i = 12'h000;
  logic [3:0]    depth_i = 4'd0;
  dcache_req_i_t pf_port_o;
  dcache_req_o_t pf_port_i;
  logic          busy_o, done_o, aborted_o;
  logic [3:0]    issued_o;

  logic gnt_en = 1'b0;
  logic rv_en = 1'b0;
  logic stray_rv = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [11:0] t1_idx [3] = '{12'h140, 12'h180, 12'h1C0};
  logic [11:0] t3_idx [2] = '{12'h0C0, 12'h080};
  logic [11:0] t6_idx [8] = '{12'h040, 12'h080, 12'h0C0, 12'h100,
                              12'h140, 12'h180, 12'h1C0, 12'h200};

  always #5 clk_i = ~clk_i;

  assign pf_port_i = '{data_gnt:    gnt_en,
                       data_rvalid: (rv_en & pf_port_o.tag_valid) | stray_rv,
                       data_rdata:  64'hDEAD_BEEF_0000_0000};

  prefetch_issue_unit #(.PfMaxDepth(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_index_i (base_index_i),
    .base_tag_i   (base_tag_i),
    .step_i       (step_i),
    .depth_i      (depth_i),
    .abort_i      (abort_i),
    .pf_port_o    (pf_port_o),
    .pf_port_i    (pf_port_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .aborted_o    (aborted_o),
    .issued_o     (issued_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic launch(input logic [11:0] idx, input logic [11:0] stp, input logic [3:0] dep);
    base_index_i = idx;
    base_tag_i   = 44'h5;
    step_i       = stp;
    depth_i      = dep;
    start_i      = 1'b1;
    cyc();
    start_i      = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   64'(pf_port_o.data_req),  64'd0);
    chk({tag, "_tv"},    64'(pf_port_o.tag_valid), 64'd0);
    chk({tag, "_be"},    64'(pf_port_o.data_be),   64'd0);
    chk({tag, "_idx"},   64'(pf_port_o.address_index), 64'd0);
    chk({tag, "_busy"},  64'(busy_o),    64'd0);
    chk({tag, "_done"},  64'(done_o),    64'd0);
    chk({tag, "_abt"},   64'(aborted_o), 64'd0);
    chk({tag, "_iss"},   64'(issued_o),  64'd0);
  endtask

  initial begin
    #1 rst_ni = 1'b0;
    #2;
    chk_idle_outputs("rst");
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Three-deep stride of 0x40 with zero-wait cache
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    launch(12'h100, 12'h040, 4'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_req",  64'(pf_port_o.data_req), 64'd1);
      chk("t1_idx",  64'(pf_port_o.address_index), 64'(t1_idx[k]));
      chk("t1_be",   64'(pf_port_o.data_be), 64'hFF);
      chk("t1_size", 64'(pf_port_o.data_size), 64'd3);
      chk("t1_we",   64'(pf_port_o.data_we), 64'd0);
      cyc();
      chk("t1_tv",   64'(pf_port_o.tag_valid), 64'd1);
      chk("t1_tag",  64'(pf_port_o.address_tag), 64'h5);
      chk("t1_treq", 64'(pf_port_o.data_req), 64'd0);
      chk("t1_kill", 64'(pf_port_o.kill_req), 64'd0);
      cyc();
      chk("t1_adv_busy", 64'(busy_o), 64'd1);
      chk("t1_adv_done", 64'(done_o), 64'd0);
      cyc();
    end
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_abt",  64'(aborted_o), 64'd0);
    chk("t1_iss",  64'(issued_o), 64'd3);
    cyc();
    chk("t1_done_pulse", 64'(done_o), 64'd0);
    chk("t1_idle_busy",  64'(busy_o), 64'd0);
    chk("t1_iss_hold",   64'(issued_o), 64'd3);

    // First address crosses the page upward
    base_index_i = 12'hFC0;
    step_i       = 12'h040;
    depth_i      = 4'd4;
    start_i      = 1'b1;
    #1;
    chk("t2_noreq", 64'(pf_port_o.data_req), 64'd0);
    cyc();
    start_i = 1'b0;
    chk("t2_done",  64'(done_o), 64'd1);
    chk("t2_abt",   64'(aborted_o), 64'd1);
    chk("t2_iss",   64'(issued_o), 64'd0);
    chk("t2_noreq2", 64'(pf_port_o.data_req), 64'd0);
    cyc();
    chk("t2_idle", 64'(done_o), 64'd0);

    // Negative stride crossing downward, then staying in page
    launch(12'h000, 12'hFC0, 4'd2);
    chk("t3a_done", 64'(done_o), 64'd1);
    chk("t3a_abt",  64'(aborted_o), 64'd1);
    chk("t3a_iss",  64'(issued_o), 64'd0);
    cyc();
    launch(12'h100, 12'hFC0, 4'd2);
    for (int k = 0; k < 2; k++) begin
      chk("t3b_idx", 64'(pf_port_o.address_index), 64'(t3_idx[k]));
      cyc();
      chk("t3b_tag", 64'(pf_port_o.address_tag), 64'h5);
      cyc();
      cyc();
    end
    chk("t3b_done", 64'(done_o), 64'd1);
    chk("t3b_abt",  64'(aborted_o), 64'd0);
    chk("t3b_iss",  64'(issued_o), 64'd2);
    cyc();

    // Grant withheld, then abort drops data_req the same cycle
    gnt_en = 1'b0;
    launch(12'h100, 12'h040, 4'd2);
    for (int k = 0; k < 5; k++) begin
      chk("t4_req", 64'(pf_port_o.data_req), 64'd1);
      chk("t4_tv",  64'(pf_port_o.tag_valid), 64'd0);
      cyc();
    end
    abort_i = 1'b1;
    #1;
    chk("t4_req_drop", 64'(pf_port_o.data_req), 64'd0);
    chk("t4_tv_abort", 64'(pf_port_o.tag_valid), 64'd0);
    cyc();
    abort_i = 1'b0;
    chk("t4_done", 64'(done_o), 64'd1);
    chk("t4_abt",  64'(aborted_o), 64'd1);
    chk("t4_iss",  64'(issued_o), 64'd0);
    chk("t4_tv_done", 64'(pf_port_o.tag_valid), 64'd0);
    cyc();
    gnt_en = 1'b1;

    // Abort in the tag cycle of the second prefetch kills it
    launch(12'h100, 12'h040, 4'd3);
    cyc();
    cyc();
    cyc();
    chk("t5_idx2", 64'(pf_port_o.address_index), 64'h180);
    cyc();
    abort_i = 1'b1;
    #1;
    chk("t5_kill", 64'(pf_port_o.kill_req), 64'd1);
    chk("t5_tv",   64'(pf_port_o.tag_valid), 64'd0);
    cyc();
    abort_i  = 1'b0;
    stray_rv = 1'b1;
    chk("t5_done",  64'(done_o), 64'd1);
    chk("t5_abt",   64'(aborted_o), 64'd1);
    chk("t5_iss",   64'(issued_o), 64'd1);
    chk("t5_nokill", 64'(pf_port_o.kill_req), 64'd0);
    cyc();
    chk("t5_stray_busy", 64'(busy_o), 64'd0);
    chk("t5_stray_iss",  64'(issued_o), 64'd1);
    stray_rv = 1'b0;
    cyc();

    // Abort seen in WAIT is remembered and applied at ADVANCE
    rv_en = 1'b0;
    launch(12'h100, 12'h040, 4'd3);
    cyc();
    chk("t7_tv", 64'(pf_port_o.tag_valid), 64'd1);
    cyc();
    abort_i = 1'b1;
    #1;
    chk("t7_wait_kill", 64'(pf_port_o.kill_req), 64'd0);
    chk("t7_wait_req",  64'(pf_port_o.data_req), 64'd0);
    cyc();
    abort_i  = 1'b0;
    stray_rv = 1'b1;
    chk("t7_wait_busy", 64'(busy_o), 64'd1);
    cyc();
    stray_rv = 1'b0;
    cyc();
    chk("t7_done", 64'(done_o), 64'd1);
    chk("t7_abt",  64'(aborted_o), 64'd1);
    chk("t7_iss",  64'(issued_o), 64'd1);
    cyc();

    // Depth 12 clamps to 8; start while busy is ignored
    rv_en = 1'b1;
    launch(12'h000, 12'h040, 4'd12);
    for (int k = 0; k < 8; k++) begin
      chk("t6_req", 64'(pf_port_o.data_req), 64'd1);
      chk("t6_idx", 64'(pf_port_o.address_index), 64'(t6_idx[k]));
      cyc();
      if (k == 0) begin
        base_index_i = 12'h800;
        depth_i      = 4'd1;
        start_i      = 1'b1;
      end
      cyc();
      start_i = 1'b0;
      cyc();
    end
    chk("t6_done", 64'(done_o), 64'd1);
    chk("t6_abt",  64'(aborted_o), 64'd0);
    chk("t6_iss",  64'(issued_o), 64'd8);
    cyc();
    chk("t6_idle", 64'(busy_o), 64'd0);

    // Asynchronous reset while waiting for data
    launch(12'h100, 12'h040, 4'd3);
    cyc();
    cyc();
    rv_en = 1'b0;
    cyc();
    cyc();
    chk("t8_tv2", 64'(pf_port_o.tag_valid), 64'd1);
    cyc();
    chk("t8_wait_busy", 64'(busy_o), 64'd1);
    chk("t8_wait_iss",  64'(issued_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_idle_outputs("t8_rst");
    cyc();
    cyc();
    chk("t8_nodone", 64'(done_o), 64'd0);
    rst_ni = 1'b1;
    cyc();
    chk("t8_post_busy", 64'(busy_o), 64'd0);
    chk("t8_post_done", 64'(done_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
